// File: rtl/rst_seq_pkg.sv
// Shared types and parameter limits for the reset sequencer.
package rst_seq_pkg;

    // Sequencer states: all asserted, staggered release, fully released.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Smallest legal values of the sequencer parameters.
    localparam int unsigned MIN_NUM_OUT        = 1;
    localparam int unsigned MIN_SYNC_STAGES    = 2;
    localparam int unsigned MIN_HOLD_CYCLES    = 1;
    localparam int unsigned MIN_STAGGER_CYCLES = 1;

    // Larger of two unsigned values, used for counter sizing.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser.
module rst_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Preset on board reset, shift zeros in once it drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset generator: synchronised release, minimum hold, then staggered
// per-output release in index order; software request replays the sequence.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sw_rst_i,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               rst_done_o,
    output logic               busy_o
);

    localparam int unsigned CNT_RAW = $clog2(max_u(HOLD_CYCLES, STAGGER_CYCLES));
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int unsigned IDX_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

    // Reject illegal parameterisations at elaboration.
    if (NUM_OUT < MIN_NUM_OUT) begin : g_chk_num_out
        $error("rst_seq_gen: NUM_OUT must be >= %0d", MIN_NUM_OUT);
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
        $error("rst_seq_gen: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_chk_hold
        $error("rst_seq_gen: HOLD_CYCLES must be >= %0d", MIN_HOLD_CYCLES);
    end
    if (STAGGER_CYCLES < MIN_STAGGER_CYCLES) begin : g_chk_stagger
        $error("rst_seq_gen: STAGGER_CYCLES must be >= %0d", MIN_STAGGER_CYCLES);
    end

    logic               rst_sync;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rst_sync_o (rst_sync)
    );

    // State, counters and outputs; board reset reaches them asynchronously.
    always_ff @(posedge clk_i or posedge rst_sync) begin
        if (rst_sync) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: software request overrides any release on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;

        if (sw_rst_i) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        idx_d    = IDX_W'(1);
                        state_d  = (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        for (int i = 0; i < int'(NUM_OUT); i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_DONE);
    end

    assign rst_o      = rst_q;
    assign rst_done_o = done_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: default instance plus a minimal one.
module tb_rst_seq_gen;

    localparam int N0 = 3, S0 = 2, H0 = 16, T0 = 4;
    localparam int N1 = 1, S1 = 3, H1 = 1,  T1 = 4;

    logic       clk;
    logic       rst_i;
    logic       sw_rst;
    logic [2:0] rst0;
    logic       done0, busy0;
    logic [0:0] rst1;
    logic       done1, busy1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rel      = 0;
    int org0     = 0;
    int base0    = S0 + H0;
    int org1     = 0;
    int base1    = S1 + H1;

    logic [4:0] sb0[$];
    logic [4:0] sb1[$];

    rst_seq_gen #(
        .NUM_OUT(N0), .SYNC_STAGES(S0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(T0)
    ) dut0 (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sw_rst_i   (sw_rst),
        .rst_o      (rst0),
        .rst_done_o (done0),
        .busy_o     (busy0)
    );

    rst_seq_gen #(
        .NUM_OUT(N1), .SYNC_STAGES(S1), .HOLD_CYCLES(H1), .STAGGER_CYCLES(T1)
    ) dut1 (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sw_rst_i   (sw_rst),
        .rst_o      (rst1),
        .rst_done_o (done1),
        .busy_o     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit k released at edge org+base+k*stag; done with the last bit.
    function automatic logic [4:0] expect_out(input int n, input int org, input int base,
                                              input int stag, input int c);
        logic [2:0] r;
        logic       d;
        r = 3'b000;
        for (int k = 0; k < n; k++) begin
            r[k] = (c < org + base + k * stag);
        end
        d = (c >= org + base + (n - 1) * stag);
        return {r, d, ~d};
    endfunction

    // Model: track the release origin per instance and push expectations.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_i) begin
            rel   = cyc;
            org0  = cyc;
            base0 = S0 + H0;
            org1  = cyc;
            base1 = S1 + H1;
        end else if (sw_rst) begin
            if (cyc > rel + S0) begin
                org0  = cyc;
                base0 = H0;
            end
            if (cyc > rel + S1) begin
                org1  = cyc;
                base1 = H1;
            end
        end
        sb0.push_back(expect_out(N0, org0, base0, T0, cyc));
        sb1.push_back(expect_out(N1, org1, base1, T1, cyc));
    end

    // Compare DUT outputs shortly after each edge against the scoreboard.
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            check_eq($sformatf("c%0d sb_depth", cyc), 32'(sb0.size() + sb1.size()), 32'd2);
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                check_eq($sformatf("c%0d d0.rst_o", cyc), 32'(rst0), 32'(e[4:2]));
                check_eq($sformatf("c%0d d0.done", cyc), 32'(done0), 32'(e[1]));
                check_eq($sformatf("c%0d d0.busy", cyc), 32'(busy0), 32'(e[0]));
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check_eq($sformatf("c%0d d1.rst_o", cyc), 32'(rst1), 32'(e[2]));
                check_eq($sformatf("c%0d d1.done", cyc), 32'(done1), 32'(e[1]));
                check_eq($sformatf("c%0d d1.busy", cyc), 32'(busy1), 32'(e[0]));
            end
        end
    end

    // One-cycle software request, sampled at the next edge.
    task automatic sw_pulse();
        sw_rst = 1'b1;
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
    endtask

    // Board reset raised between edges; outputs must react without a clock.
    task automatic rst_pulse_async();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_eq("async d0.rst_o", 32'(rst0), 32'h7);
        check_eq("async d0.done", 32'(done0), 32'h0);
        check_eq("async d0.busy", 32'(busy0), 32'h1);
        check_eq("async d1.rst_o", 32'(rst1), 32'h1);
        check_eq("async d1.done", 32'(done1), 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i  = 1'b0;
        sw_rst = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("por d0.rst_o", 32'(rst0), 32'h7);
        check_eq("por d0.busy", 32'(busy0), 32'h1);

        // Power-on release and full sequence.
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Single software pulse from DONE.
        sw_pulse();
        repeat (30) @(posedge clk);
        #1;

        // Software request held for 10 cycles starting inside HOLD.
        sw_pulse();
        repeat (5) @(posedge clk);
        #1;
        sw_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sw_rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Software request lands on the edge that would release bit 1.
        sw_pulse();
        repeat (19) @(posedge clk);
        #1;
        sw_rst = 1'b1;
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        check_eq("collide d0.rst_o", 32'(rst0), 32'h7);
        repeat (30) @(posedge clk);
        #1;

        // Board reset mid-RELEASE, then full restart.
        sw_pulse();
        repeat (17) @(posedge clk);
        #1;
        rst_pulse_async();
        repeat (30) @(posedge clk);
        #1;

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
